ram_uart_dump: RTL and testbench



---
 rtl/ram_uart_dump.sv | 150 +++++++++++++++
 tb/tb_ram_uart_dump.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_uart_dump.sv
// rtl/ram_uart_dump.sv - RAM word block read-out streamed as SYNC/payload/checksum bytes into a TX FIFO
module ram_uart_dump #(
  parameter int          ADDR_W    = 13,
  parameter int          RAM_LAT   = 2,
  parameter logic [7:0]  SYNC_BYTE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [31:0]       ram_q,
  input  logic              fifo_full,
  output logic              fifo_wrreq,
  output logic [7:0]        fifo_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_FETCH,
    S_SEND,
    S_CKSUM,
    S_DONE
  } state_t;

  // FETCH lasts RAM_LAT+1 cycles; the address is already on the bus when FETCH is entered
  localparam logic [1:0]    LAT_LAST = 2'(RAM_LAT);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   addr_inc;
  logic [ADDR_W:0]     remaining;
  logic [31:0]         word;
  logic [1:0]          byte_idx;
  logic [1:0]          lat_cnt;
  logic [7:0]          checksum;
  logic [7:0]          send_byte;

  // next word address wraps naturally at 2^ADDR_W
  assign addr_inc = addr + ADDR_W'(1);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic; every write state holds while the FIFO is full
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SYNC;
      S_SYNC:  if (!fifo_full) state_nxt = (remaining == '0) ? S_CKSUM : S_FETCH;
      S_FETCH: if (lat_cnt == LAT_LAST) state_nxt = S_SEND;
      S_SEND:  if (!fifo_full && byte_idx == 2'd3)
                 state_nxt = (remaining == CNT_ONE) ? S_CKSUM : S_FETCH;
      S_CKSUM: if (!fifo_full) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // status outputs decoded from state; busy drops in the done cycle
  always_comb begin
    busy = (state != S_IDLE) && (state != S_DONE);
    done = (state == S_DONE);
  end

  // select the current payload byte, least-significant first
  always_comb begin
    send_byte = word[7:0];
    case (byte_idx)
      2'd0: send_byte = word[7:0];
      2'd1: send_byte = word[15:8];
      2'd2: send_byte = word[23:16];
      2'd3: send_byte = word[31:24];
      default: send_byte = word[7:0];
    endcase
  end

  // datapath: counters, RAM address, word capture, checksum and registered FIFO write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= '0;
      remaining   <= '0;
      word        <= '0;
      byte_idx    <= '0;
      lat_cnt     <= '0;
      checksum    <= '0;
      ram_address <= '0;
      fifo_wrreq  <= 1'b0;
      fifo_data   <= '0;
    end else begin
      fifo_wrreq <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= start_addr;
            remaining <= word_count;
            checksum  <= '0;
            byte_idx  <= '0;
          end
        end
        S_SYNC: begin
          if (!fifo_full) begin
            fifo_wrreq <= 1'b1;
            fifo_data  <= SYNC_BYTE;
            lat_cnt    <= '0;
            if (remaining != '0) ram_address <= addr;
          end
        end
        S_FETCH: begin
          lat_cnt <= lat_cnt + 2'd1;
          if (lat_cnt == LAT_LAST) begin
            word     <= ram_q;
            byte_idx <= '0;
          end
        end
        S_SEND: begin
          if (!fifo_full) begin
            fifo_wrreq <= 1'b1;
            fifo_data  <= send_byte;
            checksum   <= checksum ^ send_byte;
            byte_idx   <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              remaining <= remaining - CNT_ONE;
              addr      <= addr_inc;
              lat_cnt   <= '0;
              if (remaining != CNT_ONE) ram_address <= addr_inc;
            end
          end
        end
        S_CKSUM: begin
          if (!fifo_full) begin
            fifo_wrreq <= 1'b1;
            fifo_data  <= checksum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_uart_dump.sv
// tb/tb_ram_uart_dump.sv - self-checking bench for ram_uart_dump with frame model and RAM model
module tb_ram_uart_dump;

  localparam int ADDR_W  = 13;
  localparam int RAM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [12:0] start_addr = '0;
  logic [13:0] word_count = '0;
  logic        busy;
  logic        done;
  logic [12:0] ram_address;
  logic [31:0] ram_q;
  logic        fifo_full = 1'b0;
  logic        fifo_wrreq;
  logic [7:0]  fifo_data;

  logic [31:0] mem [0:8191];
  logic [12:0] pipe [0:RAM_LAT-1];
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];

  int   checks = 0;
  int   failures = 0;
  int   done_seen = 0;
  logic prev_full = 1'b0;
  logic prev_done = 1'b0;
  int   full_mode = 0;
  bit   held = 1'b0;
  int   hold_cnt = 0;

  always #10 clk = ~clk;

  ram_uart_dump #(.ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT), .SYNC_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .word_count(word_count), .busy(busy), .done(done),
    .ram_address(ram_address), .ram_q(ram_q), .fifo_full(fifo_full),
    .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data)
  );

  // RAM: data for an address appears RAM_LAT clocks after the address changes
  always @(posedge clk) begin
    pipe[0] <= ram_address;
    for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
    prev_full <= fifo_full;
  end
  assign ram_q = mem[pipe[RAM_LAT-1]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // frame model: SYNC, each word LSB first with wrapping addresses, XOR of payload bytes
  task automatic build_frame(input logic [12:0] a, input int n);
    logic [7:0]  cks;
    logic [31:0] w;
    cks = 8'h00;
    exp_q.push_back(8'hFF);
    for (int i = 0; i < n; i++) begin
      w = mem[13'((int'(a) + i) % 8192)];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(w[8*b +: 8]);
        cks = cks ^ w[8*b +: 8];
      end
    end
    exp_q.push_back(cks);
  endtask

  // compare every FIFO write and every done pulse against the model
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (fifo_wrreq) begin
        check("wrreq_after_full", 32'(prev_full), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got 0x%0h expected no write", fifo_data);
        end else begin
          e = exp_q.pop_front();
          check("frame_byte", 32'(fifo_data), 32'(e));
        end
        got_q.push_back(fifo_data);
      end
      if (done) begin
        check("done_all_bytes", 32'(exp_q.size()), 32'd0);
        check("busy_low_with_done", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(prev_done), 32'd0);
        done_seen++;
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // FIFO full stimulus: off, random, or a single 10-cycle hold after the third byte
  always @(negedge clk) begin
    if (full_mode == 1) begin
      fifo_full = ($urandom_range(0, 3) == 0);
    end else if (full_mode == 2) begin
      if (hold_cnt > 0) begin
        fifo_full = 1'b1;
        hold_cnt--;
      end else if (!held && got_q.size() >= 3) begin
        held = 1'b1;
        fifo_full = 1'b1;
        hold_cnt = 9;
      end else begin
        fifo_full = 1'b0;
      end
    end else begin
      fifo_full = 1'b0;
      held = 1'b0;
    end
  end

  task automatic run_dump(input logic [12:0] a, input int n, input int mode,
                          input bit inj, input bit timed);
    int cyc;
    int limit;
    bit got;
    full_mode = mode;
    build_frame(a, n);
    got_q.delete();
    @(negedge clk);
    start_addr = a;
    word_count = 14'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    got = 1'b0;
    limit = 100 + n * 60;
    while (cyc < limit) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
      if (inj && cyc == 4) begin
        start_addr = 13'($urandom);
        word_count = 14'($urandom_range(1, 5));
        start = 1'b1;
      end
      if (cyc == 5) start = 1'b0;
    end
    check("done_within_limit", 32'(got), 32'd1);
    if (timed) check("frame_cycles", 32'(cyc), 32'(2 + n * (RAM_LAT + 5)));
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    full_mode = 0;
  endtask

  task automatic check_frame(input string name, input logic [7:0] lit [$]);
    check({name, "_len"}, 32'(got_q.size()), 32'(lit.size()));
    for (int i = 0; i < lit.size() && i < got_q.size(); i++)
      check({name, "_byte"}, 32'(got_q[i]), 32'(lit[i]));
  endtask

  initial begin
    logic [7:0]  lit [$];
    logic [12:0] ra;
    int          d0;
    int          cyc;
    int          nrand;
    logic [12:0] a;

    for (int i = 0; i < 8192; i++) mem[i] = $urandom;
    nrand = 20;

    #1 rst = 1'b1;
    #4;
    check("rst_wrreq", 32'(fifo_wrreq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(ram_address), 32'd0);
    check("rst_data", 32'(fifo_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single word
    mem[16] = 32'h11223344;
    d0 = done_seen;
    run_dump(13'h010, 1, 0, 1'b0, 1'b1);
    lit = '{8'hFF, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
    check_frame("one_word", lit);
    check("one_word_done_pulses", 32'(done_seen - d0), 32'd1);

    // two words
    mem[5] = 32'hDEADBEEF;
    mem[6] = 32'h01020304;
    run_dump(13'd5, 2, 0, 1'b0, 1'b1);
    lit = '{8'hFF, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01, 8'h26};
    check_frame("two_words", lit);

    // empty frame leaves the RAM address untouched
    ra = ram_address;
    run_dump(13'd100, 0, 0, 1'b0, 1'b1);
    lit = '{8'hFF, 8'h00};
    check_frame("zero_words", lit);
    check("zero_words_addr_held", 32'(ram_address), 32'(ra));

    // address wrap 8191 -> 0
    mem[8191] = 32'h0A0B0C0D;
    mem[0]    = 32'h10203040;
    run_dump(13'd8191, 2, 0, 1'b0, 1'b1);
    lit = '{8'hFF, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h40, 8'h30, 8'h20, 8'h10, 8'h40};
    check_frame("wrap", lit);

    // FIFO full held for 10 cycles mid-word
    mem[256] = 32'hA1B2C3D4;
    mem[257] = 32'h55667788;
    run_dump(13'h100, 2, 2, 1'b0, 1'b0);
    lit = '{8'hFF, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h88, 8'h77, 8'h66, 8'h55, 8'hC8};
    check_frame("stall", lit);

    // reset in the middle of a frame, then a fresh frame
    full_mode = 0;
    build_frame(13'h200, 3);
    got_q.delete();
    @(negedge clk);
    start_addr = 13'h200;
    word_count = 14'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (got_q.size() < 3 && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    check("reach_third_byte", 32'(got_q.size() >= 3), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("midrst_wrreq", 32'(fifo_wrreq), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_addr", 32'(ram_address), 32'd0);
    check("midrst_data", 32'(fifo_data), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_dump(13'h300, 2, 0, 1'b0, 1'b1);
    check("restart_first_byte", 32'(got_q.size() > 0 ? got_q[0] : 8'h00), 32'hFF);
    check("restart_len", 32'(got_q.size()), 32'd10);

    // randomized frames, random stalls, ignored restarts while busy
    for (int k = 0; k < nrand; k++) begin
      int n;
      int m;
      bit inj;
      a   = ($urandom_range(0, 3) == 0) ? 13'(8192 - $urandom_range(1, 3)) : 13'($urandom);
      n   = $urandom_range(0, 6);
      m   = $urandom_range(0, 1);
      inj = (n > 0) && ($urandom_range(0, 1) == 1);
      run_dump(a, n, m, inj, m == 0);
      check("rand_len", 32'(got_q.size()), 32'(n * 4 + 2));
    end

    check("done_count", 32'(done_seen), 32'(6 + nrand));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
